reg_file: RTL and testbench

//   32-entry architectural register file for the single-cycle core. It sits directly upstream
//   of the ALU and drives its a1/a2 operands. Reads are combinational with write-through bypass.

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/reg_file_sweep.sv | 45 ++++
 rtl/reg_file.sv | 77 +++++++
 tb/tb_reg_file.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file.
// Sweep FSM state codes and the hardwired-zero register index.
package reg_file_pkg;

  localparam logic [0:0] RF_CLEAR = 1'b0;
  localparam logic [0:0] RF_RUN   = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic is_zero_reg(input logic [4:0] a);
    return a == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_sweep.sv
// Post-reset clear sweep: walks idx over every entry, then enters RF_RUN.
// The top uses clr_we/idx to zero storage and ready to gate reads and writes.
module reg_file_sweep
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] idx,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      idx   <= '0;
    end else begin
      unique case (state)
        RF_CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == LAST)
            state <= RF_RUN;
        end
        RF_RUN: begin
          idx <= idx;
        end
        default: begin
          state <= RF_CLEAR;
          idx   <= '0;
        end
      endcase
    end
  end

  assign ready  = (state == RF_RUN);
  assign clr_we = (state == RF_CLEAR) && !rst;

endmodule

// File: rtl/reg_file.sv
// 32-entry register file: combinational reads with write-through bypass,
// synchronous writes, x0 hardwired to zero, cleared by a post-reset sweep.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              usr_wr;

  reg_file_sweep #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sweep (
    .clk    (clk),
    .rst    (rst),
    .clr_we (clr_we),
    .idx    (clr_idx),
    .ready  (ready)
  );

  assign usr_wr = we && (wa != ZERO);

  // Sweep and user writes are exclusive: user writes need RF_RUN.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_idx] <= '0;
    else if (!rst && ready && usr_wr)
      mem[wa] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      wr_drop <= 1'b0;
    else
      wr_drop <= !ready && usr_wr;
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] ra
  );
    logic [DATA_W-1:0] v;
    if (!ready || ra == ZERO)
      v = '0;
    else if (BYPASS && usr_wr && wa == ra)
      v = wdata;
    else
      v = mem[ra];
    return v;
  endfunction

  always_comb begin
    rdata1 = rd_port(ra1);
    rdata2 = rd_port(ra2);
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: sweep timing, vector table,
// randomized traffic against an array model, and reset corner cases.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rdata1, rdata2, wdata;
  logic        we, ready, wr_drop;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [10];

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .ra1     (ra1),
    .ra2     (ra2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .we      (we),
    .wa      (wa),
    .wdata   (wdata),
    .ready   (ready),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference read: ready gate, x0, write-through, stored value.
  function automatic logic [31:0] ref_rd(input logic rdy,
                                         input logic [4:0] ra);
    if (!rdy || ra == 0) return 32'h0;
    if (we && wa != 0 && wa == ra) return wdata;
    return model[ra];
  endfunction

  task automatic commit();
    if (we && wa != 0) model[wa] = wdata;
    tick();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wdata = '0;
    ra1 = 5'd1; ra2 = 5'd2;
    clear_model();
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd7,  32'h1,        5'd7,  5'd0,  32'h1,        32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'h2,        5'd7,  5'd7,  32'h2,        32'h2};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h2,        32'h2};
    vecs[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[9] = '{1'b1, 5'd0,  32'h123,      5'd0,  5'd31, 32'h0,        32'hA5A5A5A5};

    // Reset held two edges, then the sweep with a dropped write at +3.
    tick(); tick();
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_wr_drop", {31'b0, wr_drop}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ra1 = 5'($urandom_range(1, 31));
      ra2 = 5'($urandom_range(1, 31));
      we = (k == 3); wa = 5'd9; wdata = 32'h55;
      #1;
      check("sweep_ready", {31'b0, ready}, 32'h0);
      check("sweep_rdata1", rdata1, 32'h0);
      check("sweep_rdata2", rdata2, 32'h0);
      if (k == 4) check("sweep_drop_pulse", {31'b0, wr_drop}, 32'h1);
      if (k == 5) check("sweep_drop_end", {31'b0, wr_drop}, 32'h0);
      tick();
    end
    we = 1'b0;
    check("sweep_done_ready", {31'b0, ready}, 32'h1);
    for (int r = 0; r < 32; r++) begin
      ra1 = 5'(r); ra2 = 5'(31 - r);
      #1;
      check("post_sweep_rd1", rdata1, 32'h0);
      check("post_sweep_rd2", rdata2, 32'h0);
    end

    // Vector table: reads in the write cycle, then wr_drop after the edge.
    foreach (vecs[i]) begin
      we = vecs[i].we; wa = vecs[i].wa; wdata = vecs[i].wdata;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      check($sformatf("vec%0d_rd1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), rdata2, vecs[i].exp2);
      commit();
      check($sformatf("vec%0d_drop", i), {31'b0, wr_drop}, 32'h0);
    end

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wdata = $urandom;
      ra1 = 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      #1;
      check("rand_rd1", rdata1, ref_rd(1'b1, ra1));
      check("rand_rd2", rdata2, ref_rd(1'b1, ra2));
      commit();
      check("rand_drop", {31'b0, wr_drop}, 32'h0);
    end

    // Reset in RUN with a same-cycle write to x3: rst wins.
    we = 1'b1; wa = 5'd3; wdata = 32'h77; rst = 1'b1;
    tick();
    clear_model();
    check("rst_run_drop", {31'b0, wr_drop}, 32'h0);
    check("rst_run_ready", {31'b0, ready}, 32'h0);
    we = 1'b0; rst = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("mid_sweep_ready", {31'b0, ready}, 32'h0);
    // Restart at idx=20, again with a write that must vanish.
    rst = 1'b1; we = 1'b1; wa = 5'd3; wdata = 32'h99;
    tick();
    check("rst_mid_drop", {31'b0, wr_drop}, 32'h0);
    rst = 1'b0; we = 1'b0;
    for (int k = 0; k < 31; k++) tick();
    check("restart_ready_31", {31'b0, ready}, 32'h0);
    tick();
    check("restart_ready_32", {31'b0, ready}, 32'h1);
    ra1 = 5'd3; ra2 = 5'd31;
    #1;
    check("restart_x3", rdata1, 32'h0);
    check("restart_x31", rdata2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
